// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: default widths
// and FSM state encoding.
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 32;
  localparam int unsigned MULT_CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/result bus between the issuing pipeline and the sequential multiplier.
interface seq_multiplier_if
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
);

  logic             start;
  logic             isSigned;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             multStall;
  logic             done;
  logic [WIDTH-1:0] productHi;
  logic [WIDTH-1:0] productLo;

  modport master (
    output start, isSigned, opA, opB,
    input  multStall, done, productHi, productLo
  );

  modport slave (
    input  start, isSigned, opA, opB,
    output multStall, done, productHi, productLo
  );

endinterface

// File: rtl/twos_negate.sv
// Combinational two's-complement negation, shared by the operand-magnitude
// and result fix-up paths of the multiplier.
module twos_negate
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] neg_c
);

  assign neg_c = ~a + WIDTH'(1);

endmodule

// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier producing a 2*WIDTH product over ~WIDTH cycles.
// Optional MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH,
  parameter int unsigned CNT_W = MULT_CNT_W
) (
  input logic             clock,
  input logic             reset,
  seq_multiplier_if.slave bus
);

  localparam int unsigned      PW        = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  mult_state_e state_q, state_d;

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             result_neg_q;
  logic [PW-1:0]    prod_q;

  logic             load_c;
  logic             step_c;
  logic             finish_c;

  logic [1:0][WIDTH-1:0] op_raw_c;
  logic [1:0][WIDTH-1:0] op_neg_c;
  logic [1:0][WIDTH-1:0] op_mag_c;

  logic [WIDTH:0]   sum_c;
  logic [PW-1:0]    step_prod_c;
  logic [PW-1:0]    final_prod_c;
  logic [PW-1:0]    final_neg_c;

  // Operand magnitudes; the most-negative value negates to itself, which is
  // exactly its unsigned magnitude.
  assign op_raw_c[0] = bus.opA;
  assign op_raw_c[1] = bus.opB;

  for (genvar i = 0; i < 2; i++) begin : g_op_mag
    twos_negate #(.WIDTH(WIDTH)) u_neg_op (
      .a     (op_raw_c[i]),
      .neg_c (op_neg_c[i])
    );
    assign op_mag_c[i] = (bus.isSigned && op_raw_c[i][WIDTH-1]) ? op_neg_c[i] : op_raw_c[i];
  end

  // One shift-add step: conditional add into the upper half, then shift
  // {carry, acc, mplier} right by one.
  assign sum_c       = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign step_prod_c = {sum_c, mplier_q[WIDTH-1:1]};

`ifdef MULT_EARLY_TERM_EN
  logic [CNT_W-1:0] rem_c;
  logic [WIDTH-1:0] rem_mask_c;

  // Remaining multiplier bits sit in the low rem_c bits after this step;
  // when they are all zero the rest of the run is pure shifting.
  assign rem_c        = LAST_STEP - cnt_q;
  assign rem_mask_c   = (WIDTH'(1) << rem_c) - WIDTH'(1);
  assign finish_c     = ~|(step_prod_c[WIDTH-1:0] & rem_mask_c);
  assign final_prod_c = step_prod_c >> rem_c;
`else
  assign finish_c     = (cnt_q == LAST_STEP);
  assign final_prod_c = step_prod_c;
`endif

  twos_negate #(.WIDTH(PW)) u_neg_prod (
    .a     (final_prod_c),
    .neg_c (final_neg_c)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    load_c        = 1'b0;
    step_c        = 1'b0;
    bus.multStall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load_c  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        step_c = 1'b1;
        if (finish_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          load_c  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Stall follows start combinationally so the issuing instruction freezes.
    bus.multStall = (state_q == S_RUN) | load_c;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      result_neg_q <= 1'b0;
      prod_q       <= '0;
    end else begin
      if (load_c) begin
        mcand_q      <= op_mag_c[0];
        mplier_q     <= op_mag_c[1];
        acc_q        <= '0;
        cnt_q        <= '0;
        result_neg_q <= bus.isSigned & (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
      end else if (step_c) begin
        acc_q    <= step_prod_c[PW-1:WIDTH];
        mplier_q <= step_prod_c[WIDTH-1:0];
        cnt_q    <= cnt_q + CNT_W'(1);
      end
      if (step_c && finish_c) begin
        prod_q <= result_neg_q ? final_neg_c : final_prod_c;
      end
    end
  end

  assign bus.done      = (state_q == S_DONE);
  assign bus.productHi = prod_q[PW-1:WIDTH];
  assign bus.productLo = prod_q[WIDTH-1:0];

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed table, back-to-back issue,
// mid-run reset and randomized operands against an arithmetic reference.
module tb_seq_multiplier;
  import mult_pkg::*;

  localparam int unsigned W = MULT_WIDTH;
`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    bit             sgn;
    logic [2*W-1:0] exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  seq_multiplier_if #(.WIDTH(W)) bus ();

  seq_multiplier #(.WIDTH(W), .CNT_W(MULT_CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input bit sgn);
    longint         sa, sb;
    logic [63:0]    ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  // Cycles from the issue cycle up to and including the done cycle.
  function automatic int ref_latency(input logic [W-1:0] b, input bit sgn);
    logic [W-1:0] m;
    int           steps;
    m     = (sgn && b[W-1]) ? -b : b;
    steps = 1;
    for (int i = 0; i < int'(W); i++) begin
      if (m[i]) steps = i + 1;
    end
    return EARLY ? steps + 1 : int'(W) + 1;
  endfunction

  // Called just after a falling edge; returns with lat = cycle count at done.
  task automatic wait_done(output int lat, output int stalls);
    stalls = 0;
    for (lat = 1; lat < 200; lat++) begin
      #1;
      if (bus.done) break;
      if (bus.multStall) stalls++;
      @(negedge clock);
    end
  endtask

  task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit sgn, input logic [63:0] exp);
    int lat, stalls, issue_stall;
    bus.start    = 1'b1;
    bus.opA      = a;
    bus.opB      = b;
    bus.isSigned = sgn;
    #1;
    issue_stall = bus.multStall ? 1 : 0;
    @(negedge clock);
    bus.start    = 1'b0;
    bus.opA      = $urandom;
    bus.opB      = $urandom;
    bus.isSigned = 1'($urandom_range(0, 1));
    wait_done(lat, stalls);
    check({name, " product"}, {bus.productHi, bus.productLo}, exp);
    check({name, " latency"}, 64'(lat), 64'(ref_latency(b, sgn)));
    check({name, " stall cycles"}, 64'(stalls + issue_stall), 64'(ref_latency(b, sgn)));
    check({name, " stall in done cycle"}, 64'(bus.multStall), 64'(0));
    @(negedge clock);
    #1;
    check({name, " done pulse width"}, 64'(bus.done), 64'(0));
  endtask

  initial begin
    vec_t           vecs[12];
    int             lat, stalls;
    bit             seen_done;
    logic [W-1:0]   ra, rb;
    bit             rs;

    vecs[0]  = '{a: 32'd5000,      b: 32'd2,          sgn: 1'b0, exp: 64'd10000};
    vecs[1]  = '{a: 32'hFFFF_FFFD, b: 32'd7,          sgn: 1'b1, exp: 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[2]  = '{a: 32'h8000_0000, b: 32'h8000_0000,  sgn: 1'b1, exp: 64'h4000_0000_0000_0000};
    vecs[3]  = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF,  sgn: 1'b0, exp: 64'hFFFF_FFFE_0000_0001};
    vecs[4]  = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF,  sgn: 1'b1, exp: 64'h0000_0000_0000_0001};
    vecs[5]  = '{a: 32'h8000_0000, b: 32'h8000_0000,  sgn: 1'b0, exp: 64'h4000_0000_0000_0000};
    vecs[6]  = '{a: 32'h1234_5678, b: 32'd0,          sgn: 1'b0, exp: 64'd0};
    vecs[7]  = '{a: 32'hFFFF_FFFF, b: 32'h8000_0000,  sgn: 1'b1, exp: 64'h0000_0000_8000_0000};
    vecs[8]  = '{a: 32'h7FFF_FFFF, b: 32'h8000_0000,  sgn: 1'b1, exp: 64'hC000_0000_8000_0000};
    vecs[9]  = '{a: 32'd7,         b: 32'hFFFF_FFFD,  sgn: 1'b1, exp: 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[10] = '{a: 32'h0001_0001, b: 32'd3,          sgn: 1'b0, exp: 64'h0000_0000_0003_0003};
    vecs[11] = '{a: 32'hFFFF_FFFF, b: 32'd1,          sgn: 1'b0, exp: 64'h0000_0000_FFFF_FFFF};

    bus.start    = 1'b0;
    bus.isSigned = 1'b0;
    bus.opA      = '0;
    bus.opB      = '0;

    // Reset state
    #1;
    check("reset multStall", 64'(bus.multStall), 64'(0));
    check("reset done", 64'(bus.done), 64'(0));
    check("reset productHi", 64'(bus.productHi), 64'(0));
    check("reset productLo", 64'(bus.productLo), 64'(0));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;

    for (int i = 0; i < 12; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp);
    end

    // Start held high: RUN ignores it, DONE re-issues with no idle gap.
    bus.start    = 1'b1;
    bus.opA      = 32'd6;
    bus.opB      = 32'd7;
    bus.isSigned = 1'b0;
    @(negedge clock);
    bus.opA = 32'd9;
    bus.opB = 32'd9;
    wait_done(lat, stalls);
    check("b2b first product", {bus.productHi, bus.productLo}, 64'd42);
    check("b2b first latency", 64'(lat), 64'(ref_latency(32'd7, 1'b0)));
    check("b2b stall in done cycle", 64'(bus.multStall), 64'(1));
    @(negedge clock);
    bus.start = 1'b0;
    wait_done(lat, stalls);
    check("b2b second product", {bus.productHi, bus.productLo}, 64'd81);
    check("b2b second latency", 64'(lat), 64'(ref_latency(32'd9, 1'b0)));
    @(negedge clock);
    #1;

    // Reset in the middle of a run aborts without a done pulse.
    bus.start    = 1'b1;
    bus.opA      = 32'h0001_2345;
    bus.opB      = 32'hF0F0_1234;
    bus.isSigned = 1'b0;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (10) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("abort multStall", 64'(bus.multStall), 64'(0));
    check("abort done", 64'(bus.done), 64'(0));
    check("abort productHi", 64'(bus.productHi), 64'(0));
    check("abort productLo", 64'(bus.productLo), 64'(0));
    @(negedge clock);
    @(negedge clock);
    reset     = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      seen_done |= bus.done;
      @(negedge clock);
    end
    #1;
    check("abort no done pulse", 64'(seen_done), 64'(0));
    check("abort product held zero", {bus.productHi, bus.productLo}, 64'd0);
    run_check("after abort", 32'd7, 32'd6, 1'b0, 64'd42);

    // Randomized operands against the arithmetic reference.
    for (int r = 0; r < 40; r++) begin
      ra = $urandom;
      rb = (r % 4 == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
      if (r % 7 == 3) ra = 32'h8000_0000;
      if (r % 9 == 5) rb = 32'hFFFF_FFFF;
      rs = 1'($urandom_range(0, 1));
      run_check($sformatf("rand%0d", r), ra, rb, rs, ref_product(ra, rb, rs));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
